// File: rtl/fpu_issue_ctrl.sv
// Issue and writeback scheduler for one shared multi-latency FPU (add/sub, mul, div).
// Define FPU_CTRL_PERF_EN to add saturating perf_issue_cnt / perf_stall_cnt outputs.
module fpu_issue_ctrl #(
  parameter int LAT_ADDSUB = 3,
  parameter int LAT_MUL    = 4,
  parameter int LAT_DIV    = 8,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [1:0]       fpu_op_mode,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  input  logic [31:0]      fpu_result,
  output logic             rsp_valid,
  output logic [31:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
`ifdef FPU_CTRL_PERF_EN
  output logic [15:0]      perf_issue_cnt,
  output logic [15:0]      perf_stall_cnt,
`endif
  output logic             busy
);

  localparam logic [1:0] UNIT_AS  = 2'd0;
  localparam logic [1:0] UNIT_MUL = 2'd1;
  localparam logic [1:0] UNIT_DIV = 2'd2;

  // Slot p holds the op whose result is sampled p+1 edges from now.
  logic [LAT_DIV-1:0]            r_slot_vld;
  logic [LAT_DIV-1:0][1:0]       r_slot_unit;
  logic [LAT_DIV-1:0][TAG_W-1:0] r_slot_tag;
  logic [LAT_DIV-1:0]            w_slot_vld_nxt;
  logic [LAT_DIV-1:0][1:0]       w_slot_unit_nxt;
  logic [LAT_DIV-1:0][TAG_W-1:0] w_slot_tag_nxt;

  logic             r_init;
  logic             r_last_sub;
  logic [1:0]       r_op_mode;
  logic [1:0]       w_op_mode_nxt;
  logic [31:0]      r_fpu_a;
  logic [31:0]      r_fpu_b;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_result;
  logic [TAG_W-1:0] r_rsp_tag;

  logic [1:0] w_req_unit;
  int         w_req_lat;
  logic       w_collide;
  logic       w_conflict;
  logic       w_ready;
  logic       w_accept;

  // Map the requested opcode to its execution unit and latency.
  always_comb begin
    w_req_unit = UNIT_AS;
    w_req_lat  = LAT_ADDSUB;
    case (req_op)
      2'b10: begin
        w_req_unit = UNIT_MUL;
        w_req_lat  = LAT_MUL;
      end
      2'b11: begin
        w_req_unit = UNIT_DIV;
        w_req_lat  = LAT_DIV;
      end
      default: begin
        w_req_unit = UNIT_AS;
        w_req_lat  = LAT_ADDSUB;
      end
    endcase
  end

  // Stall on a writeback slot collision or when the op-mode mux is owned by another unit.
  always_comb begin
    w_collide = 1'b0;
    for (int p = 1; p < LAT_DIV; p++) begin
      w_collide = w_collide | ((p == w_req_lat) & r_slot_vld[p]);
    end
    w_conflict = r_slot_vld[1] & (r_slot_unit[1] != w_req_unit);
    w_ready    = r_init & ~w_collide & ~w_conflict;
    w_accept   = req_valid & w_ready;
  end

  // Shift the scoreboard toward slot 0 and drop a newly accepted op into slot L-1.
  always_comb begin
    w_slot_vld_nxt  = '0;
    w_slot_unit_nxt = '0;
    w_slot_tag_nxt  = '0;
    for (int p = 0; p < LAT_DIV - 1; p++) begin
      w_slot_vld_nxt[p]  = r_slot_vld[p+1];
      w_slot_unit_nxt[p] = r_slot_unit[p+1];
      w_slot_tag_nxt[p]  = r_slot_tag[p+1];
    end
    for (int p = 0; p < LAT_DIV; p++) begin
      w_slot_vld_nxt[p]  = (w_accept && (p == w_req_lat - 1)) ? 1'b1       : w_slot_vld_nxt[p];
      w_slot_unit_nxt[p] = (w_accept && (p == w_req_lat - 1)) ? w_req_unit : w_slot_unit_nxt[p];
      w_slot_tag_nxt[p]  = (w_accept && (p == w_req_lat - 1)) ? req_tag    : w_slot_tag_nxt[p];
    end
  end

  // A new op owns the mode; otherwise steer the mux to the unit whose capture cycle comes next.
  always_comb begin
    w_op_mode_nxt = r_op_mode;
    if (w_accept) begin
      w_op_mode_nxt = req_op;
    end else if (r_slot_vld[1]) begin
      case (r_slot_unit[1])
        UNIT_MUL: w_op_mode_nxt = 2'b10;
        UNIT_DIV: w_op_mode_nxt = 2'b11;
        default:  w_op_mode_nxt = {1'b0, r_last_sub};
      endcase
    end else begin
      w_op_mode_nxt = r_op_mode;
    end
  end

  // Scoreboard, FPU input registers and ready-enable state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_init      <= 1'b0;
      r_slot_vld  <= '0;
      r_slot_unit <= '0;
      r_slot_tag  <= '0;
      r_op_mode   <= 2'b00;
      r_last_sub  <= 1'b0;
      r_fpu_a     <= 32'd0;
      r_fpu_b     <= 32'd0;
    end else begin
      r_init      <= 1'b1;
      r_slot_vld  <= w_slot_vld_nxt;
      r_slot_unit <= w_slot_unit_nxt;
      r_slot_tag  <= w_slot_tag_nxt;
      r_op_mode   <= w_op_mode_nxt;
      if (w_accept) begin
        r_fpu_a    <= req_a;
        r_fpu_b    <= req_b;
        r_last_sub <= (w_req_unit == UNIT_AS) ? req_op[0] : r_last_sub;
      end else begin
        r_fpu_a    <= r_fpu_a;
        r_fpu_b    <= r_fpu_b;
        r_last_sub <= r_last_sub;
      end
    end
  end

  // Capture the FPU result for the op sitting in slot 0 and emit a one-cycle response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= 32'd0;
      r_rsp_tag    <= '0;
    end else if (r_slot_vld[0]) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_result <= fpu_result;
      r_rsp_tag    <= r_slot_tag[0];
    end else begin
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= r_rsp_result;
      r_rsp_tag    <= r_rsp_tag;
    end
  end

`ifdef FPU_CTRL_PERF_EN
  logic [15:0] r_issue_cnt;
  logic [15:0] r_stall_cnt;

  // Saturating issue and stall counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_issue_cnt <= 16'd0;
      r_stall_cnt <= 16'd0;
    end else begin
      if (w_accept && (r_issue_cnt != 16'hFFFF)) begin
        r_issue_cnt <= r_issue_cnt + 16'd1;
      end else begin
        r_issue_cnt <= r_issue_cnt;
      end
      if (req_valid && !w_ready && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
    end
  end

  assign perf_issue_cnt = r_issue_cnt;
  assign perf_stall_cnt = r_stall_cnt;
`endif

  assign req_ready   = w_ready;
  assign fpu_op_mode = r_op_mode;
  assign fpu_a       = r_fpu_a;
  assign fpu_b       = r_fpu_b;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_result  = r_rsp_result;
  assign rsp_tag     = r_rsp_tag;
  assign busy        = (|r_slot_vld) | r_rsp_valid;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with a lookup-table FPU model and a capture-order scoreboard.
`timescale 1ns/1ps
module tb_fpu_issue_ctrl;

  localparam int LA = 3;
  localparam int LM = 4;
  localparam int LD = 8;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'b00;
  logic [31:0]   req_a = 32'd0;
  logic [31:0]   req_b = 32'd0;
  logic [TW-1:0] req_tag = '0;
  logic [1:0]    fpu_op_mode;
  logic [31:0]   fpu_a;
  logic [31:0]   fpu_b;
  logic [31:0]   fpu_result;
  logic          rsp_valid;
  logic [31:0]   rsp_result;
  logic [TW-1:0] rsp_tag;
  logic          busy;
`ifdef FPU_CTRL_PERF_EN
  logic [15:0]   perf_issue_cnt;
  logic [15:0]   perf_stall_cnt;
`endif

  fpu_issue_ctrl #(.LAT_ADDSUB(LA), .LAT_MUL(LM), .LAT_DIV(LD), .TAG_W(TW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .fpu_op_mode(fpu_op_mode), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_result(fpu_result),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_tag(rsp_tag),
`ifdef FPU_CTRL_PERF_EN
    .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_acc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Known IEEE-754 results; anything else maps to a distinct per-op pattern.
  function automatic logic [31:0] fpu_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = 32'h5A5A_0000 ^ a ^ {b[15:0], b[31:16]} ^ {30'd0, op};
    case ({op, a, b})
      {2'b00, 32'h3F800000, 32'h40000000}: r = 32'h40400000;
      {2'b00, 32'h40000000, 32'h40000000}: r = 32'h40800000;
      {2'b00, 32'h3F800000, 32'h3F800000}: r = 32'h40000000;
      {2'b01, 32'h40400000, 32'h3F800000}: r = 32'h40000000;
      {2'b01, 32'h3F800000, 32'h3F800000}: r = 32'h00000000;
      {2'b10, 32'h40000000, 32'h40400000}: r = 32'h40C00000;
      {2'b10, 32'h3FC00000, 32'h40000000}: r = 32'h40400000;
      {2'b11, 32'h40C00000, 32'h40000000}: r = 32'h40400000;
      {2'b11, 32'h3F800000, 32'h40000000}: r = 32'h3F000000;
      default: r = r;
    endcase
    return r;
  endfunction

  function automatic int lat_of(input logic [1:0] op);
    return op[1] ? (op[0] ? LD : LM) : LA;
  endfunction

  // Shared FPU model: per-unit pipelines fed from the registered fpu_a/fpu_b/op.
  logic [31:0] ha[LD] = '{default: 32'd0};
  logic [31:0] hb[LD] = '{default: 32'd0};
  logic [1:0]  hop[LD] = '{default: 2'd0};

  always @(negedge clk) begin
    for (int i = LD - 1; i > 0; i--) begin
      ha[i]  = ha[i-1];
      hb[i]  = hb[i-1];
      hop[i] = hop[i-1];
    end
    ha[0]  = fpu_a;
    hb[0]  = fpu_b;
    hop[0] = fpu_op_mode;
  end

  always_comb begin
    case (fpu_op_mode)
      2'b10:   fpu_result = fpu_fn(2'b10, ha[LM-1], hb[LM-1]);
      2'b11:   fpu_result = fpu_fn(2'b11, ha[LD-1], hb[LD-1]);
      default: fpu_result = fpu_fn({1'b0, hop[LA-1][0]}, ha[LA-1], hb[LA-1]);
    endcase
  end

  typedef struct { int at; logic [31:0] res; logic [TW-1:0] tag; } ev_t;
  ev_t expq[$];
  ev_t obsq[$];

  // Record each acceptance with its expected capture edge, kept sorted by that edge.
  always @(posedge clk) begin
    ev_t e;
    int  idx;
    cyc = cyc + 1;
    if (reset_n && req_valid && req_ready) begin
      last_acc = cyc;
      e.at  = cyc + lat_of(req_op);
      e.res = fpu_fn(req_op, req_a, req_b);
      e.tag = req_tag;
      idx = expq.size();
      for (int i = 0; i < expq.size(); i++) begin
        if (expq[i].at > e.at) begin
          idx = i;
          break;
        end
      end
      expq.insert(idx, e);
    end
  end

  // Response monitor against the scoreboard.
  always @(negedge clk) begin
    ev_t e;
    if (!reset_n) begin
      expq.delete();
    end else begin
      if (rsp_valid) begin
        e.at = cyc; e.res = rsp_result; e.tag = rsp_tag;
        obsq.push_back(e);
        if (expq.size() == 0) begin
          chk("rsp_spurious", {31'd0, rsp_valid}, 32'd0);
        end else begin
          e = expq.pop_front();
          chk("rsp_cycle", 32'(cyc), 32'(e.at));
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
        end
      end
      while (expq.size() > 0 && expq[0].at <= cyc) begin
        e = expq.pop_front();
        chk("rsp_missing_at", 32'(cyc), 32'(e.at - 1000));
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TW-1:0] tag);
    int n;
    req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
    #1;
    n = 0;
    while (!req_ready && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("issue_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  typedef struct {
    logic [1:0]    op;
    logic [31:0]   a;
    logic [31:0]   b;
    logic [TW-1:0] tag;
    logic [31:0]   res;
    int            lat;
  } vec_t;
  vec_t vt[8];

  initial begin
    int n;
    int k;
    vt[0] = '{2'b00, 32'h3F800000, 32'h40000000, 4'd3,  32'h40400000, 3};
    vt[1] = '{2'b01, 32'h40400000, 32'h3F800000, 4'd5,  32'h40000000, 3};
    vt[2] = '{2'b00, 32'h40000000, 32'h40000000, 4'd1,  32'h40800000, 3};
    vt[3] = '{2'b01, 32'h3F800000, 32'h3F800000, 4'd0,  32'h00000000, 3};
    vt[4] = '{2'b10, 32'h40000000, 32'h40400000, 4'd7,  32'h40C00000, 4};
    vt[5] = '{2'b10, 32'h3FC00000, 32'h40000000, 4'd2,  32'h40400000, 4};
    vt[6] = '{2'b11, 32'h40C00000, 32'h40000000, 4'd9,  32'h40400000, 8};
    vt[7] = '{2'b11, 32'h3F800000, 32'h40000000, 4'd15, 32'h3F000000, 8};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_op_mode", {30'd0, fpu_op_mode}, 32'd0);
    chk("rst_fpu_a", fpu_a, 32'd0);
    chk("rst_fpu_b", fpu_b, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("ready_before_first_edge", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("ready_after_first_edge", {31'd0, req_ready}, 32'd1);

    // Isolated ops from the table
    for (int i = 0; i < 8; i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b, vt[i].tag);
      chk("tbl_fpu_a", fpu_a, vt[i].a);
      chk("tbl_fpu_b", fpu_b, vt[i].b);
      chk("tbl_op_mode", {30'd0, fpu_op_mode}, {30'd0, vt[i].op});
      chk("tbl_busy_inflight", {31'd0, busy}, 32'd1);
      n = 0;
      while (!rsp_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("tbl_rsp_seen", {31'd0, rsp_valid}, 32'd1);
      chk("tbl_latency", 32'(cyc - last_acc), 32'(vt[i].lat));
      chk("tbl_result", rsp_result, vt[i].res);
      chk("tbl_tag", 32'(rsp_tag), 32'(vt[i].tag));
      @(negedge clk);
      chk("tbl_pulse_one_cycle", {31'd0, rsp_valid}, 32'd0);
      chk("tbl_busy_idle", {31'd0, busy}, 32'd0);
    end

    // Div then mul: mul result overtakes div
    obsq.delete();
    req_op = 2'b11; req_a = 32'h40C00000; req_b = 32'h40000000; req_tag = 4'd4; req_valid = 1'b1;
    #1;
    chk("ooo_div_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    k = last_acc;
    req_op = 2'b10; req_a = 32'h40000000; req_b = 32'h40400000; req_tag = 4'd6;
    #1;
    chk("ooo_mul_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("ooo_mul_edge", 32'(last_acc), 32'(k + 1));
    repeat (10) @(negedge clk);
    chk("ooo_count", 32'(obsq.size()), 32'd2);
    if (obsq.size() >= 2) begin
      chk("ooo_first_tag", 32'(obsq[0].tag), 32'd6);
      chk("ooo_first_at", 32'(obsq[0].at), 32'(k + 5));
      chk("ooo_first_res", obsq[0].res, 32'h40C00000);
      chk("ooo_second_tag", 32'(obsq[1].tag), 32'd4);
      chk("ooo_second_at", 32'(obsq[1].at), 32'(k + 8));
      chk("ooo_second_res", obsq[1].res, 32'h40400000);
    end

    // Eight back-to-back adds
    obsq.delete();
    for (int i = 0; i < 8; i++) begin
      req_op = 2'b00; req_a = 32'h3F800000; req_b = 32'h40000000; req_tag = 4'(i); req_valid = 1'b1;
      #1;
      chk("b2b_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
    end
    req_valid = 1'b0;
    k = last_acc - 7;
    repeat (6) @(negedge clk);
    chk("b2b_count", 32'(obsq.size()), 32'd8);
    for (int i = 0; i < 8 && i < obsq.size(); i++) begin
      chk("b2b_tag", 32'(obsq[i].tag), 32'(i));
      chk("b2b_at", 32'(obsq[i].at), 32'(k + 3 + i));
    end

    // Add then sub while the add is in its capture cycle
    issue(2'b00, 32'h3F800000, 32'h3F800000, 4'd13);
    @(negedge clk);
    issue(2'b01, 32'h40400000, 32'h3F800000, 4'd14);
    chk("sub_in_add_capture_mode", {30'd0, fpu_op_mode}, 32'd1);
    repeat (6) @(negedge clk);

    // Writeback collision: add right after mul lands on the same slot
    issue(2'b10, 32'h40000000, 32'h40400000, 4'd11);
    req_op = 2'b00; req_a = 32'h40000000; req_b = 32'h40000000; req_tag = 4'd12; req_valid = 1'b1;
    #1;
    chk("collide_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    #1;
    chk("collide_ready_next", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (8) @(negedge clk);

    // Reset in flight discards the div
    obsq.delete();
    issue(2'b11, 32'h40C00000, 32'h40000000, 4'd5);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ready", {31'd0, req_ready}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_no_rsp", 32'(obsq.size()), 32'd0);
    chk("midrst_busy_after", {31'd0, busy}, 32'd0);
    issue(2'b00, 32'h3F800000, 32'h40000000, 4'd3);
    repeat (5) @(negedge clk);
    chk("midrst_add_count", 32'(obsq.size()), 32'd1);
    if (obsq.size() >= 1) begin
      chk("midrst_add_res", obsq[0].res, 32'h40400000);
      chk("midrst_add_at", 32'(obsq[0].at), 32'(last_acc + 3));
    end

    // Mul held while a div capture is due: one stall cycle
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    obsq.delete();
    issue(2'b11, 32'h3F800000, 32'h40000000, 4'd8);
    k = last_acc;
    repeat (6) @(negedge clk);
    req_op = 2'b10; req_a = 32'h3FC00000; req_b = 32'h40000000; req_tag = 4'd10; req_valid = 1'b1;
    #1;
    chk("stall_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    #1;
    chk("stall_ready_next", {31'd0, req_ready}, 32'd1);
    chk("stall_div_mode", {30'd0, fpu_op_mode}, 32'd3);
    @(negedge clk);
    req_valid = 1'b0;
    chk("stall_mul_edge", 32'(last_acc), 32'(k + 8));
    repeat (6) @(negedge clk);
    chk("stall_count", 32'(obsq.size()), 32'd2);
    if (obsq.size() >= 2) begin
      chk("stall_div_tag", 32'(obsq[0].tag), 32'd8);
      chk("stall_div_res", obsq[0].res, 32'h3F000000);
      chk("stall_mul_tag", 32'(obsq[1].tag), 32'd10);
      chk("stall_mul_at", 32'(obsq[1].at), 32'(k + 12));
      chk("stall_mul_res", obsq[1].res, 32'h40400000);
    end
`ifdef FPU_CTRL_PERF_EN
    chk("perf_issue", 32'(perf_issue_cnt), 32'd2);
    chk("perf_stall", 32'(perf_stall_cnt), 32'd1);
`endif

    repeat (10) @(negedge clk);
    chk("drain", 32'(expq.size()), 32'd0);
    chk("final_busy", {31'd0, busy}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 Parameter LAT_ADDSUB, default 3: edges from the fpu input-register edge to the edge that samples a valid add/sub fpu_result.
REQ-002 Parameter LAT_MUL, default 4: the same latency for multiply.
REQ-003 Parameter LAT_DIV, default 8: the same latency for divide.
REQ-004 Parameter TAG_W, default 4: width of the request/response tag.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  request may be accepted this cycle.
REQ-009 req_op  in  2  00 add, 01 sub, 10 mul, 11 div.
REQ-010 req_a, req_b  in  32  IEEE-754 single operands.
REQ-011 req_tag  in  TAG_W  requester tag, returned with the result.
REQ-012 fpu_op_mode  out  2  op_mode to the shared FPU, registered.
REQ-013 fpu_a, fpu_b  out  32  operands to the shared FPU, registered.
REQ-014 fpu_result  in  32  shared FPU result, selected combinationally by fpu_op_mode.
REQ-015 rsp_valid  out  1  one-cycle result pulse, no backpressure.
REQ-016 rsp_result  out  32; rsp_tag  out  TAG_W.
REQ-017 busy  out  1  at least one operation in flight.

Function
REQ-018 Accept on any rising edge k where req_valid and req_ready are both 1; at edge k, load fpu_a/fpu_b/fpu_op_mode from req_a/req_b/req_op.
REQ-019 Define L as the LAT_* value of the accepted op's unit; sample fpu_result and the entry's tag at edge k+L; drive rsp_valid=1 with rsp_result/rsp_tag for exactly the cycle after edge k+L.
REQ-020 Track in-flight ops in a scoreboard of LAT_DIV slots {valid, unit, tag}; slot p is captured p+1 edges from now; on acceptance, write slot L-1; shift toward slot 0 every edge.
REQ-021 The capture cycle is the cycle ending at the sampling edge; during it, fpu_op_mode SHALL select the capturing unit (00/01 for addsub, 10 mul, 11 div).
REQ-022 req_ready=0 when slot L-1 will be occupied after the shift (writeback collision).
REQ-023 req_ready=0 when a capture is due in the cycle following edge k and the capturing unit differs from the requested unit.
REQ-024 If neither condition holds, req_ready=1; it depends on req_op, and a requester SHALL hold req_* stable while req_valid=1 and req_ready=0.
REQ-025 When no op is accepted, fpu_op_mode SHALL take the unit code of the next-cycle capture if one is due (addsub keeps its last 00/01), else hold; fpu_a/fpu_b hold.
REQ-026 An add may be accepted in a sub capture cycle and vice versa; the new op's code drives fpu_op_mode.
REQ-027 busy=1 iff any slot is valid or rsp_valid=1.
REQ-028 Results leave in capture order, which may differ from issue order (an add issued after a div returns first).

Reset
REQ-029 While reset_n=0: req_ready=0, rsp_valid=0, busy=0, all slots invalid, fpu_op_mode=00, fpu_a=fpu_b=0, rsp_result=0, rsp_tag=0.
REQ-030 Reset asserted mid-operation discards all in-flight ops; no rsp_valid is produced for them after release.
REQ-031 req_ready may first assert in the cycle after the first rising edge following reset_n release.

Configuration
REQ-032 With FPU_CTRL_PERF_EN defined: 16-bit outputs perf_issue_cnt (accepted requests) and perf_stall_cnt (cycles with req_valid=1, req_ready=0); both saturate at 0xFFFF and reset to 0.
REQ-033 Without FPU_CTRL_PERF_EN, those ports and counters do not exist; all other behaviour is identical.

Verification
REQ-034 Add 0x3F800000+0x40000000, tag 3, accepted at edge k -> rsp_valid after edge k+3, rsp_result 0x40400000, rsp_tag 3.
REQ-035 Div 0x40C00000/0x40000000 at k, then mul 0x40000000*0x40400000 at k+1 -> mul rsp 0x40C00000 after edge k+5 before div rsp 0x40400000 after edge k+8; tags correct.
REQ-036 Mul held valid when a div capture is due in the cycle after the next edge -> req_ready=0 for that cycle only; mul accepted next cycle; both results correct.
REQ-037 Back-to-back adds, tags 0..7, on 8 consecutive edges -> 8 consecutive rsp pulses, tags 0..7 in order, no stalls.
REQ-038 reset_n pulsed low 2 cycles after a div accept -> no rsp_valid for it; busy=0; a new add then completes normally.
REQ-039 With FPU_CTRL_PERF_EN, after REQ-036 -> perf_issue_cnt=2, perf_stall_cnt=1.
